spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//  - Decodes a spike train (1-cycle pulses from a LIF neuron's spike_o) back into an
//    unsigned rate word: spikes counted over a fixed window of WINDOW enabled cycles.
//  - Sits downstream of the neuron array.
//  - Each result goes out on a valid/ready interface to the readout/debug logic.
// PARAMETERS
//  WINDOW  16'd256  window length in enabled clk_i cycles; legal range 2..2^WIN_W
//  WIN_W   16       window counter width; must satisfy WINDOW <= 2^WIN_W
//  CNT_W   8        spike count / rate_o width; count saturates at 2^CNT_W-1
//  ISI_W   8        inter-spike-interval width (SPIKE_RATE_DECODER_ISI_EN builds only)
// PORTS
//  clk_i      in   1      clock, all state on rising edge
//  rst_ni     in   1      asynchronous active-low reset
//  en_i       in   1      decoding enable; low = idle, partial window discarded
//  spike_i    in   1      spike input; every cycle high counts as one spike
//  ready_i    in   1      consumer accepts rate_o when valid_o&ready_i
//  ovr_clr_i  in   1      clears sticky overrun_o
//  rate_o     out  CNT_W  spike count of the last completed window
//  valid_o    out  1      rate_o holds an unconsumed result
//  overrun_o  out  1      sticky: a finished window was dropped because the slot was full
//  isi_o      out  ISI_W  last inter-spike interval in cycles (only with the macro)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): win_cnt=0, spk_cnt=0, state=IDLE; rate_o=0, valid_o=0,
//    overrun_o=0, isi_o=0.
//  - FSM IDLE: counters held at 0.
//    - en_i=1 -> COUNT. The first counted cycle is the cycle after en_i is sampled high.
//  - FSM COUNT, per edge:
//    - win_cnt <= win_cnt+1.
//    - If spike_i: spk_cnt <= min(spk_cnt+1, 2^CNT_W-1).
//    - en_i=0 -> IDLE, win_cnt=spk_cnt=0, partial window discarded.
//  - Window end is the edge where win_cnt==WINDOW-1 and en_i=1.
//    - final = spk_cnt + spike_i, saturated.
//    - win_cnt and spk_cnt <= 0; the next window starts on the next cycle with no gap.
//  - Output slot, evaluated on the window-end edge:
//    - Slot free (!valid_o) or draining (valid_o&ready_i): rate_o <= final, valid_o <= 1.
//    - Otherwise: result dropped, rate_o unchanged, overrun_o <= 1.
//  - Latency: rate_o/valid_o update on the same edge that samples the last window cycle.
//  - Handshake:
//    - rate_o is stable while valid_o=1 and not yet accepted.
//    - Accept (valid_o&ready_i) with no new result that edge -> valid_o <= 0.
//    - Accept and new result on the same edge -> valid_o stays 1, rate_o = new value.
//    - ready_i is ignored while valid_o=0.
//  - Overrun:
//    - ovr_clr_i=1 -> overrun_o <= 0.
//    - Set and clear on the same edge: set wins.
//  - en_i low does not touch a pending rate_o/valid_o or overrun_o.
//  - Reset mid-window: everything cleared immediately; the partial window is lost.
// CONFIGURATION
//  - SPIKE_RATE_DECODER_ISI_EN defined: adds port isi_o and an ISI counter.
//    - isi_cnt increments every COUNT cycle, saturating at 2^ISI_W-1, and clears to 0 on
//      each spike.
//    - On a spike with seen_first=1: isi_o <= min(isi_cnt+1, 2^ISI_W-1).
//    - The first spike only sets seen_first. Consecutive-cycle spikes give isi_o=1.
//    - IDLE clears isi_cnt and seen_first; isi_o holds its value.
//  - Macro undefined: no isi_o port and no ISI logic. Window/rate behaviour is identical.
// TESTING
//  1. WINDOW=8, en_i=1, spike_i on alternate cycles -> rate_o=4, valid_o=1 after cycle 8.
//  2. CNT_W=4, WINDOW=32, spike_i held 1 -> rate_o=15 (saturated), overrun_o=0.
//  3. WINDOW=8, ready_i=0 for two windows:
//     - first rate_o is held, overrun_o=1 after the 2nd window;
//     - ovr_clr_i pulse -> overrun_o=0.
//  4. ready_i=1 on the window-end edge with valid_o=1 -> valid_o stays 1, rate_o = new
//     count, overrun_o=0.
//  5. en_i dropped after 3 spikes mid-window -> no result; re-enable with 2 spikes in the
//     window -> rate_o=2.
//  6. rst_ni=0 mid-window -> all outputs 0 with no clock edge.
//     - ISI_EN build: spikes at cycles 10 and 15 -> isi_o=5.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train rate decoder: counts spikes over WINDOW enabled cycles and presents the
// result on a valid/ready slot. Define SPIKE_RATE_DECODER_ISI_EN to add the isi_o output.
module spike_rate_decoder #(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned ISI_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             spike_i,
    input  logic             ready_i,
    input  logic             ovr_clr_i,
    output logic [CNT_W-1:0] rate_o,
    output logic             valid_o,
    output logic             overrun_o
`ifdef SPIKE_RATE_DECODER_ISI_EN
    ,
    output logic [ISI_W-1:0] isi_o
`endif
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Reject configurations whose window cannot be represented by the counter.
    if (WINDOW < 2 || CNT_W < 1 || ISI_W < 1 ||
        (WIN_W < 32 && 64'(WINDOW) > (64'd1 << WIN_W))) begin : g_bad_param
        $error("spike_rate_decoder: illegal parameter combination");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [WIN_W-1:0] win_cnt, win_d;
    logic [CNT_W-1:0] spk_cnt, spk_d, spk_inc, final_cnt;
    logic             win_end;
    logic             accept;
    logic             load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            win_cnt <= '0;
            spk_cnt <= '0;
        end else begin
            state   <= state_d;
            win_cnt <= win_d;
            spk_cnt <= spk_d;
        end
    end

    always_comb begin
        state_d   = state;
        win_d     = win_cnt;
        spk_d     = spk_cnt;
        win_end   = 1'b0;
        spk_inc   = (spk_cnt == CNT_MAX) ? CNT_MAX : spk_cnt + 1'b1;
        final_cnt = spike_i ? spk_inc : spk_cnt;
        case (state)
            IDLE: begin
                win_d = '0;
                spk_d = '0;
                if (en_i) state_d = COUNT;
            end
            COUNT: begin
                if (!en_i) begin
                    state_d = IDLE;
                    win_d   = '0;
                    spk_d   = '0;
                end else if (win_cnt == WIN_LAST) begin
                    // Last cycle of the window: its own spike is folded into final_cnt.
                    win_end = 1'b1;
                    win_d   = '0;
                    spk_d   = '0;
                end else begin
                    win_d = win_cnt + 1'b1;
                    spk_d = final_cnt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = valid_o & ready_i;
    assign load   = win_end & (~valid_o | ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rate_o  <= '0;
            valid_o <= 1'b0;
        end else if (load) begin
            rate_o  <= final_cnt;
            valid_o <= 1'b1;
        end else if (accept) begin
            valid_o <= 1'b0;
        end
    end

    // A dropped result outranks a clear on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               overrun_o <= 1'b0;
        else if (win_end && !load) overrun_o <= 1'b1;
        else if (ovr_clr_i)        overrun_o <= 1'b0;
    end

`ifdef SPIKE_RATE_DECODER_ISI_EN
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic [ISI_W-1:0] isi_cnt, isi_inc;
    logic             seen_first;

    assign isi_inc = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            isi_cnt    <= '0;
            seen_first <= 1'b0;
            isi_o      <= '0;
        end else if (state == COUNT && en_i) begin
            if (spike_i) begin
                isi_cnt    <= '0;
                seen_first <= 1'b1;
                if (seen_first) isi_o <= isi_inc;
            end else begin
                isi_cnt <= isi_inc;
            end
        end else begin
            isi_cnt    <= '0;
            seen_first <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: one 8-cycle-window instance for handshake,
// overrun and enable tests, one 32-cycle/4-bit instance for count saturation.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, spike, ready, ovr_clr;
    logic [7:0] rate;
    logic       valid, overrun;
    logic       en2, spike2, ready2, ovr_clr2;
    logic [3:0] rate2;
    logic       valid2, overrun2;
`ifdef SPIKE_RATE_DECODER_ISI_EN
    logic [7:0] isi;
    logic [7:0] isi2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW(8), .WIN_W(16), .CNT_W(8), .ISI_W(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .spike_i(spike), .ready_i(ready),
        .ovr_clr_i(ovr_clr), .rate_o(rate), .valid_o(valid), .overrun_o(overrun)
`ifdef SPIKE_RATE_DECODER_ISI_EN
        , .isi_o(isi)
`endif
    );

    spike_rate_decoder #(.WINDOW(32), .WIN_W(16), .CNT_W(4), .ISI_W(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .spike_i(spike2), .ready_i(ready2),
        .ovr_clr_i(ovr_clr2), .rate_o(rate2), .valid_o(valid2), .overrun_o(overrun2)
`ifdef SPIKE_RATE_DECODER_ISI_EN
        , .isi_o(isi2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one full 8-cycle window on dut_a, spike pattern LSB first.
    task automatic run_win(input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            spike = pat[i];
            step();
        end
        spike = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rate !== 8'd0)  begin errors++; $display("FAIL reset_rate got %0d exp 0", rate); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (valid2 !== 1'b0 || rate2 !== 4'd0) begin errors++; $display("FAIL reset_b got v=%b r=%0d exp 0/0", valid2, rate2); end
`ifdef SPIKE_RATE_DECODER_ISI_EN
        checks++; if (isi !== 8'd0) begin errors++; $display("FAIL reset_isi got %0d exp 0", isi); end
`endif
    endtask

`ifdef SPIKE_RATE_DECODER_ISI_EN
    task automatic test_isi();
        en = 1'b1; step();
        for (int i = 0; i < 8; i++) begin
            spike = (i == 2 || i == 7);
            step();
            if (i == 2) begin
                checks++; if (isi !== 8'd0) begin errors++; $display("FAIL isi_first got %0d exp 0", isi); end
            end
        end
        spike = 1'b0;
        checks++; if (isi !== 8'd5) begin errors++; $display("FAIL isi_gap5 got %0d exp 5", isi); end
        checks++; if (rate !== 8'd2 || valid !== 1'b1) begin errors++; $display("FAIL isi_rate got r=%0d v=%b exp 2/1", rate, valid); end
        en = 1'b0; step();
        ready = 1'b1; step(); ready = 1'b0;
        en = 1'b1; step();
        spike = 1'b1; step(); step();
        checks++; if (isi !== 8'd1) begin errors++; $display("FAIL isi_consec got %0d exp 1", isi); end
        spike = 1'b0; en = 1'b0; step();
        checks++; if (isi !== 8'd1 || valid !== 1'b0) begin errors++; $display("FAIL isi_hold got isi=%0d v=%b exp 1/0", isi, valid); end
    endtask
`endif

    task automatic test_alternate();
        en = 1'b1; step();
        for (int i = 0; i < 8; i++) begin
            spike = (i % 2 == 0);
            step();
            if (i == 6) begin
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL alt_early_valid got %b exp 0", valid); end
            end
        end
        spike = 1'b0;
        checks++; if (rate !== 8'd4 || valid !== 1'b1) begin errors++; $display("FAIL alt_rate got r=%0d v=%b exp 4/1", rate, valid); end
        en = 1'b0; step();
        ready = 1'b1; step(); ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL alt_accept got %b exp 0", valid); end
    endtask

    task automatic test_overrun();
        en = 1'b1; step();
        run_win(8'b0000_0111);
        checks++; if (rate !== 8'd3 || valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_win1 got r=%0d v=%b o=%b exp 3/1/0", rate, valid, overrun); end
        // Second window back to back; clear pulse lands on the same edge as the drop.
        for (int i = 0; i < 8; i++) begin
            spike   = (i < 5);
            ovr_clr = (i == 7);
            step();
        end
        spike = 1'b0; ovr_clr = 1'b0;
        checks++; if (rate !== 8'd3 || valid !== 1'b1) begin errors++; $display("FAIL ovr_held got r=%0d v=%b exp 3/1", rate, valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
        en = 1'b0; step();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_en_low got %b exp 1", overrun); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0 || valid !== 1'b1 || rate !== 8'd3) begin errors++; $display("FAIL ovr_clear got o=%b v=%b r=%0d exp 0/1/3", overrun, valid, rate); end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; step();
        for (int i = 0; i < 8; i++) begin
            spike = (i < 6);
            ready = (i == 7);
            step();
            if (i == 3) begin
                checks++; if (rate !== 8'd3 || valid !== 1'b1) begin errors++; $display("FAIL b2b_stable got r=%0d v=%b exp 3/1", rate, valid); end
            end
        end
        spike = 1'b0; ready = 1'b0;
        checks++; if (rate !== 8'd6 || valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_new got r=%0d v=%b o=%b exp 6/1/0", rate, valid, overrun); end
        en = 1'b0; step();
        ready = 1'b1; step(); ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", valid); end
    endtask

    task automatic test_en_drop();
        en = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            spike = (i < 3);
            step();
        end
        spike = 1'b0; en = 1'b0; step();
        repeat (10) step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL endrop_noresult got %b exp 0", valid); end
        en = 1'b1; step();
        run_win(8'b1100_0000);
        checks++; if (rate !== 8'd2 || valid !== 1'b1) begin errors++; $display("FAIL endrop_rate got r=%0d v=%b exp 2/1", rate, valid); end
        en = 1'b0; step();
        ready = 1'b1; step(); ready = 1'b0;
    endtask

    task automatic test_saturate();
        en2 = 1'b1; step();
        spike2 = 1'b1;
        repeat (31) step();
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL sat_early got %b exp 0", valid2); end
        step();
        checks++; if (rate2 !== 4'd15 || valid2 !== 1'b1 || overrun2 !== 1'b0) begin errors++; $display("FAIL sat_rate got r=%0d v=%b o=%b exp 15/1/0", rate2, valid2, overrun2); end
        spike2 = 1'b0; en2 = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        en = 1'b1; step();
        run_win(8'h01);
        run_win(8'h03);
        spike = 1'b1; repeat (3) step();
        checks++; if (valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL rmid_setup got v=%b o=%b exp 1/1", valid, overrun); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rate !== 8'd0 || valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rmid_clear got r=%0d v=%b o=%b exp 0/0/0", rate, valid, overrun); end
        checks++; if (rate2 !== 4'd0 || valid2 !== 1'b0) begin errors++; $display("FAIL rmid_clear_b got r=%0d v=%b exp 0/0", rate2, valid2); end
`ifdef SPIKE_RATE_DECODER_ISI_EN
        checks++; if (isi !== 8'd0) begin errors++; $display("FAIL rmid_isi got %0d exp 0", isi); end
`endif
        en = 1'b0; spike = 1'b0;
        #3 rst_n = 1'b1;
        repeat (10) step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_lost got %b exp 0", valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; spike = 1'b0; ready = 1'b0; ovr_clr = 1'b0;
        en2 = 1'b0; spike2 = 1'b0; ready2 = 1'b0; ovr_clr2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        step();
`ifdef SPIKE_RATE_DECODER_ISI_EN
        test_isi();
`endif
        test_alternate();
        test_overrun();
        test_back_to_back();
        test_en_drop();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
